// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Holds the overlap-mode encodings and the width of the history fill counter.
package seq_det_pkg;

  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;

  // The fill counter must be able to represent every value from 0 to len.
  function automatic int fill_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter with a sticky all-ones flag.
// Latency: the count updates on the clock edge after inc; no backpressure, inc is never refused.
// A clear applies first, so an increment in the same cycle leaves the count at 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] base;
  logic [W-1:0] nxt;
  logic         base_sat;
  logic         nxt_sat;

  always_comb begin
    base     = clr ? '0 : cnt;
    base_sat = clr ? 1'b0 : sat;
    nxt      = base;
    nxt_sat  = base_sat;
    if (inc) begin
      if (base != MAX) begin
        nxt = base + 1'b1;
      end
      if (nxt == MAX) begin
        nxt_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= nxt;
      sat <= nxt_sat;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial detector: compares the last LEN sampled bits against a live pattern.
// Latency: z is valid in the same cycle as the final bit; y pulses one cycle later.
// No backpressure: en acts only as a sample strobe, and bits are dropped when en=0.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [LEN-1:0]   pattern,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = fill_w(LEN);

  logic [LEN-1:0] hist;
  logic [FW-1:0]  fill;
  logic [LEN-1:0] shifted;
  logic           fill_ok;

  assign shifted = {hist[LEN-2:0], din};
  // The incoming bit completes the window, so LEN-1 held bits are enough to compare.
  assign fill_ok = (fill >= FW'(LEN - 1));
  assign z       = rst & en & fill_ok & (shifted == pattern);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (en) begin
      y <= z;
      if (z && (overlap == MODE_NONOVERLAP)) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= shifted;
        if (fill != FW'(LEN)) begin
          fill <= fill + 1'b1;
        end
      end
    end else begin
      y <= 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (z),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector; a second instance with CNT_W=2 covers saturation.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic [3:0] pattern = 4'b1011;
  logic       overlap = 1'b1;
  logic       clr_cnt = 1'b0;
  logic       z, y, cnt_sat;
  logic [7:0] match_cnt;
  logic       z2, y2, cnt_sat2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern),
    .overlap(overlap), .clr_cnt(clr_cnt),
    .z(z), .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_pattern_detector #(.LEN(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .pattern(pattern),
    .overlap(overlap), .clr_cnt(clr_cnt),
    .z(z2), .y(y2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; din = 1'b1;
    #1;
    checks++;
    if (z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", z); end
    tick(); tick();
    checks++;
    if (y !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0 || z !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got y=%b cnt=%0d sat=%b z=%b exp all 0", y, match_cnt, cnt_sat, z);
    end
    rst = 1'b1; en = 1'b0;
  endtask

  // Plays a 7-bit stream MSB first, checking z per bit and y one cycle later.
  task automatic run_stream(input string name, input logic [6:0] s, input logic [6:0] ez);
    for (int i = 6; i >= 0; i--) begin
      en = 1'b1; din = s[i];
      #1;
      checks++;
      if (z !== ez[i]) begin failures++; $display("FAIL %s_z bit%0d got=%b exp=%b", name, 7 - i, z, ez[i]); end
      tick();
      checks++;
      if (y !== ez[i]) begin failures++; $display("FAIL %s_y bit%0d got=%b exp=%b", name, 7 - i, y, ez[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_overlap;
    do_reset(); pattern = 4'b1011; overlap = 1'b1;
    run_stream("ovl", 7'b1011011, 7'b0001001);
    checks++;
    if (match_cnt !== 8'd2) begin failures++; $display("FAIL ovl_cnt got=%0d exp=2", match_cnt); end
  endtask

  task automatic test_nonoverlap;
    do_reset(); pattern = 4'b1011; overlap = 1'b0;
    run_stream("novl", 7'b1011011, 7'b0001000);
    checks++;
    if (match_cnt !== 8'd1) begin failures++; $display("FAIL novl_cnt got=%0d exp=1", match_cnt); end
  endtask

  task automatic test_en_gap;
    logic [2:0] s;
    do_reset(); pattern = 4'b1011; overlap = 1'b1;
    s = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      en = 1'b1; din = s[i];
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      en = 1'b0; din = 1'b1;
      #1;
      checks++;
      if (z !== 1'b0) begin failures++; $display("FAIL gap_z cyc%0d got=%b exp=0", i, z); end
      tick();
      checks++;
      if (y !== 1'b0) begin failures++; $display("FAIL gap_y cyc%0d got=%b exp=0", i, y); end
    end
    en = 1'b1; din = 1'b1;
    #1;
    checks++;
    if (z !== 1'b1) begin failures++; $display("FAIL gap_resume_z got=%b exp=1", z); end
    tick();
    checks++;
    if (y !== 1'b1) begin failures++; $display("FAIL gap_resume_y got=%b exp=1", y); end
    en = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [2:0] s;
    do_reset(); pattern = 4'b1011; overlap = 1'b1;
    s = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      en = 1'b1; din = s[i];
      tick();
    end
    rst = 1'b0; en = 1'b1; din = 1'b1;
    #1;
    checks++;
    if (z !== 1'b0) begin failures++; $display("FAIL midrst_z got=%b exp=0", z); end
    tick();
    checks++;
    if (y !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state got y=%b cnt=%0d sat=%b exp 0", y, match_cnt, cnt_sat);
    end
    rst = 1'b1;
    // The four bits after reset must form a fresh window: 1,0,1,1 matches only on the last.
    s = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      en = 1'b1; din = s[i];
      #1;
      checks++;
      if (z !== 1'b0) begin failures++; $display("FAIL midrst_refill_z step%0d got=%b exp=0", 2 - i, z); end
      tick();
    end
    din = 1'b1;
    #1;
    checks++;
    if (z !== 1'b1) begin failures++; $display("FAIL midrst_refill_match got=%b exp=1", z); end
    tick();
    en = 1'b0;
  endtask

  task automatic test_saturation;
    logic [1:0] ecnt [7];
    logic       esat [7];
    ecnt = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    esat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(); pattern = 4'b1111; overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; din = 1'b1;
      tick();
      checks++;
      if (match_cnt2 !== ecnt[i] || cnt_sat2 !== esat[i]) begin
        failures++;
        $display("FAIL sat bit%0d got cnt=%0d sat=%b exp cnt=%0d sat=%b", i + 1, match_cnt2, cnt_sat2, ecnt[i], esat[i]);
      end
    end
    checks++;
    if (match_cnt !== 8'd4 || cnt_sat !== 1'b0) begin
      failures++; $display("FAIL sat_wide got cnt=%0d sat=%b exp cnt=4 sat=0", match_cnt, cnt_sat);
    end
    en = 1'b0;
  endtask

  task automatic test_clr_with_match;
    do_reset(); pattern = 4'b1111; overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; din = 1'b1;
      tick();
    end
    checks++;
    if (match_cnt !== 8'd5) begin failures++; $display("FAIL clr_pre_cnt got=%0d exp=5", match_cnt); end
    clr_cnt = 1'b1; en = 1'b1; din = 1'b1;
    #1;
    checks++;
    if (z !== 1'b1) begin failures++; $display("FAIL clr_match_z got=%b exp=1", z); end
    tick();
    checks++;
    if (match_cnt !== 8'd1 || cnt_sat !== 1'b0 || y !== 1'b1) begin
      failures++;
      $display("FAIL clr_match got cnt=%0d sat=%b y=%b exp cnt=1 sat=0 y=1", match_cnt, cnt_sat, y);
    end
    en = 1'b0;
    tick();
    checks++;
    if (match_cnt !== 8'd0 || cnt_sat2 !== 1'b0 || match_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL clr_idle got cnt=%0d cnt2=%0d sat2=%b exp 0", match_cnt, match_cnt2, cnt_sat2);
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_pattern_change;
    logic [2:0] s;
    do_reset(); pattern = 4'b1011; overlap = 1'b1;
    s = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      en = 1'b1; din = s[i];
      tick();
    end
    // History 101 is kept; the new pattern 1010 completes with din=0.
    pattern = 4'b1010; din = 1'b0;
    #1;
    checks++;
    if (z !== 1'b1) begin failures++; $display("FAIL patchg_z got=%b exp=1", z); end
    pattern = 4'b1011;
    #1;
    checks++;
    if (z !== 1'b0) begin failures++; $display("FAIL patchg_live got=%b exp=0", z); end
    tick();
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_en_gap();
    test_mid_reset();
    test_saturation();
    test_clr_with_match();
    test_pattern_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
